// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type, datapath width and iteration count.
package mdu_pkg;

    localparam int MDU_WIDTH = 16;
    localparam int MDU_ITER  = 16;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIN  = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative 16x16 multiply / 16/16 divide sharing one 32-bit shift register and
// one 17-bit adder. Signed MULT/DIV only when MDU_SIGNED_EN is defined.
module mult_div_unit
    import mdu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [MDU_WIDTH-1:0] a_in,
    input  logic [MDU_WIDTH-1:0] b_in,
    input  logic                 abort,
    output logic [MDU_WIDTH-1:0] hi,
    output logic [MDU_WIDTH-1:0] lo,
    output logic                 busy,
    output logic                 done
);

    localparam int W = MDU_WIDTH;

    mdu_state_e     state;
    logic [3:0]     cnt;
    logic [2*W-1:0] acc;     // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [W-1:0]   dvsr;    // multiplicand or divisor magnitude
    logic [W-1:0]   a_raw;
    logic           is_div;
    logic           dz;
    logic [W-1:0]   hi_r, lo_r;

    // operand magnitudes
    logic [W-1:0] a_mag, b_mag;
`ifdef MDU_SIGNED_EN
    logic sgn_a, sgn_b;
    logic neg_q, neg_r;

    always_comb begin
        sgn_a = op[0] & a_in[W-1];
        sgn_b = op[0] & b_in[W-1];
        a_mag = sgn_a ? -a_in : a_in;
        b_mag = sgn_b ? -b_in : b_in;
    end
`else
    logic unused_op0;
    assign unused_op0 = op[0];
    assign a_mag = a_in;
    assign b_mag = b_in;
`endif

    // shared adder: mult adds multiplicand to the upper half, div subtracts the
    // divisor from the shifted remainder (carry out = no borrow)
    logic [W:0]   add_x, add_y;
    logic         add_cin;
    logic [W+1:0] add_sum;
    logic [2*W-1:0] acc_nxt;

    always_comb begin
        if (is_div) begin
            add_x   = acc[2*W-1:W-1];
            add_y   = ~{1'b0, dvsr};
            add_cin = 1'b1;
        end else begin
            add_x   = {1'b0, acc[2*W-1:W]};
            add_y   = {1'b0, dvsr};
            add_cin = 1'b0;
        end
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(W+1){1'b0}}, add_cin};
    end

    always_comb begin
        if (is_div)
            acc_nxt = add_sum[W+1] ? {add_sum[W-1:0], acc[W-2:0], 1'b1}
                                   : {acc[2*W-2:0], 1'b0};
        else
            acc_nxt = acc[0] ? {add_sum[W:0], acc[W-1:1]}
                             : {1'b0, acc[2*W-1:W], acc[W-1:1]};
    end

    logic [W-1:0] res_hi, res_lo;

    always_comb begin
`ifdef MDU_SIGNED_EN
        if (is_div) begin
            res_lo = neg_q ? -acc[W-1:0]   : acc[W-1:0];
            res_hi = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
        end else begin
            {res_hi, res_lo} = neg_q ? -acc : acc;
        end
`else
        {res_hi, res_lo} = acc;
`endif
        // divide by zero reports the raw dividend, regardless of signedness
        if (is_div && dz) begin
            res_hi = a_raw;
            res_lo = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            dvsr   <= '0;
            a_raw  <= '0;
            is_div <= 1'b0;
            dz     <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
`ifdef MDU_SIGNED_EN
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        acc    <= {{W{1'b0}}, (op[1] ? a_mag : b_mag)};
                        dvsr   <= op[1] ? b_mag : a_mag;
                        a_raw  <= a_in;
                        is_div <= op[1];
                        dz     <= op[1] && (b_in == '0);
                        cnt    <= '0;
                        state  <= S_CALC;
`ifdef MDU_SIGNED_EN
                        neg_q  <= sgn_a ^ sgn_b;
                        neg_r  <= sgn_a;
`endif
                    end
                end
                S_CALC: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'(MDU_ITER-1))
                            state <= S_FIN;
                    end
                end
                S_FIN: begin
                    if (!abort) begin
                        hi_r <= res_hi;
                        lo_r <= res_lo;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // FIN presents the corrected result in the same cycle as the done pulse;
    // a flush or reset in that cycle withholds both
    assign busy = (state != S_IDLE);
    assign done = (state == S_FIN) && !abort && !rst;
    assign hi   = done ? res_hi : hi_r;
    assign lo   = done ? res_lo : lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors plus randomized ops with
// spurious starts and aborts, checked against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a_in, b_in;
    logic        abort;
    logic [15:0] hi, lo;
    logic        busy, done;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_last;

`ifdef MDU_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    mult_div_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a_in  (a_in),
        .b_in  (b_in),
        .abort (abort),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        int x, y, q, r;
        bit sg;
        logic [31:0] p;
        sg = SIGNED_EN && o[0];
        x = sg ? int'($signed(a)) : int'({16'b0, a});
        y = sg ? int'($signed(b)) : int'({16'b0, b});
        if (!o[1]) begin
            p = 32'(x * y);
            return p;
        end
        if (b == 16'h0000) return {a, 16'hFFFF};
        q = x / y;
        r = x % y;
        return {r[15:0], q[15:0]};
    endfunction

    // monitor: pop on every done, otherwise result registers must hold
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic [31:0] e;
                    e = sb_q.pop_front();
                    chk("result", {hi, lo}, e);
                    exp_last = e;
                end
            end else begin
                chk("hold", {hi, lo}, exp_last);
            end
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         input int abort_at, input int spur_at,
                         input bit chk_const, input logic [31:0] econst);
        logic [31:0] m;
        m = model(o, a, b);
        if (abort_at == 0) sb_q.push_back(m);
        start = 1'b1; op = o; a_in = a; b_in = b; abort = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            @(posedge clk); #1;
            start = (c == spur_at) && !(abort_at != 0 && c > abort_at);
            if (start) begin
                op = 2'($urandom); a_in = 16'($urandom); b_in = 16'($urandom);
            end
            abort = (c == abort_at);
            @(negedge clk);
            if (abort_at != 0 && c > abort_at) begin
                chk("busy_after_abort", {31'b0, busy}, 32'd0);
                break;
            end
            chk("busy", {31'b0, busy}, 32'd1);
            chk("done_timing", {31'b0, done}, {31'b0, (c == 17 && abort_at == 0)});
            if (c == 17 && chk_const && abort_at == 0)
                chk("spec_vector", {hi, lo}, econst);
        end
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; a_in = '0; b_in = '0; abort = 1'b0;
        exp_last = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_hilo", {hi, lo}, 32'h0);

        // abort alone and abort with start in IDLE do nothing
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 start = 1'b1; op = 2'b00; a_in = 16'h1234; b_in = 16'h0002;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_with_abort_ignored", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;

        do_op(2'b00, 16'hFFFF, 16'hFFFF, 0, 0, 1, 32'hFFFE_0001);
        do_op(2'b01, 16'hFFFD, 16'h0005, 0, 0, 1, SIGNED_EN ? 32'hFFFF_FFF1 : 32'h0004_FFF1);
        do_op(2'b10, 16'h0064, 16'h0007, 0, 0, 1, 32'h0002_000E);
        do_op(2'b11, 16'hFFF9, 16'h0002, 0, 0, 1, SIGNED_EN ? 32'hFFFF_FFFD : 32'h0001_7FFC);
        do_op(2'b10, 16'h04D2, 16'h0000, 0, 0, 1, 32'h04D2_FFFF);
        do_op(2'b11, 16'h8ABC, 16'h0000, 0, 0, 1, 32'h8ABC_FFFF);
        do_op(2'b11, 16'h8000, 16'hFFFF, 0, 0, 1, SIGNED_EN ? 32'h0000_8000 : 32'h8000_0000);

        // completed op, then a flushed divide with a stray start
        do_op(2'b00, 16'h0002, 16'h0003, 0, 0, 1, 32'h0000_0006);
        do_op(2'b10, 16'h0064, 16'h0007, 5, 3, 0, 32'h0);
        @(negedge clk);
        chk("abort_retains", {hi, lo}, 32'h0000_0006);
        @(posedge clk); #1;

        // reset in the middle of a divide
        start = 1'b1; op = 2'b11; a_in = 16'h7123; b_in = 16'h0011;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1 start = 1'b0;
        end
        rst = 1'b1; exp_last = 32'h0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midop_rst_busy", {31'b0, busy}, 32'd0);
        chk("midop_rst_hilo", {hi, lo}, 32'h0);
        @(posedge clk); #1;
        do_op(2'b11, 16'hFF00, 16'h0010, 0, 0, 1, SIGNED_EN ? 32'h0000_FFF0 : 32'h0000_0FF0);

        // randomized back-to-back traffic
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  ro;
            logic [15:0] ra, rb;
            int ab, sp;
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = 16'h0000;
                1:       rb = 16'hFFFF;
                default: rb = 16'($urandom);
            endcase
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 17)) : 0;
            sp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 17)) : 0;
            do_op(ro, ra, rb, ab, sp, 0, 32'h0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
